// File: rtl/dma_bus_requester_pkg.sv
// Shared bus-control definitions for the 68000 DMA bus requester:
// FSM encoding, tenure/holdoff defaults, bus levels and output decode.
package dma_bus_requester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_WAIT_FREE = 3'd2,
        ST_OWN       = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_NEGATE    = 3'd5,
        ST_HOLDOFF   = 3'd6
    } state_e;

    localparam logic [7:0] MAX_TENURE_DEF = 8'd64;
    localparam logic [3:0] HOLDOFF_DEF    = 4'd4;

    localparam logic SYNC_RESET_VAL = 1'b1;
    localparam logic BUS_ASSERTED_N = 1'b0;
    localparam logic BUS_NEGATED_N  = 1'b1;

    typedef struct packed {
        logic dma_gnt;
        logic br_n_out;
        logic br_n_oe;
        logic bgack_n_out;
        logic bgack_n_oe;
    } bus_outs_t;

    localparam bus_outs_t OUTS_RELEASED = '{
        dma_gnt:     1'b0,
        br_n_out:    BUS_NEGATED_N,
        br_n_oe:     1'b0,
        bgack_n_out: BUS_NEGATED_N,
        bgack_n_oe:  1'b0
    };

    // Output values for the state being entered; BR and BGACK drive sets are disjoint.
    function automatic bus_outs_t decode_outs(input state_e nxt, input logic was_own);
        bus_outs_t o;
        o = OUTS_RELEASED;
        case (nxt)
            ST_REQUEST, ST_WAIT_FREE: begin
                o.br_n_out = BUS_ASSERTED_N;
                o.br_n_oe  = 1'b1;
            end
            ST_OWN: begin
                o.bgack_n_out = BUS_ASSERTED_N;
                o.bgack_n_oe  = 1'b1;
                o.dma_gnt     = was_own;
            end
            ST_RELEASE: begin
                o.bgack_n_out = BUS_ASSERTED_N;
                o.bgack_n_oe  = 1'b1;
            end
            ST_NEGATE: begin
                o.bgack_n_out = BUS_NEGATED_N;
                o.bgack_n_oe  = 1'b1;
            end
            ST_IDLE, ST_HOLDOFF: begin
                o = OUTS_RELEASED;
            end
            default: begin
                o = OUTS_RELEASED;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dma_bus_requester_if.sv
// Local DMA handshake plus 68000 arbitration pins of the bus requester.
interface dma_bus_requester_if;

    logic DMA_REQ;
    logic DMA_BUSY;
    logic DMA_GNT;
    logic BG_n_IN;
    logic BGACK_n_IN;
    logic AS_n_IN;
    logic DTACK_n_IN;
    logic BR_n_OUT;
    logic BR_n_OE;
    logic BGACK_n_OUT;
    logic BGACK_n_OE;

    modport master (
        input  DMA_REQ, DMA_BUSY, BG_n_IN, BGACK_n_IN, AS_n_IN, DTACK_n_IN,
        output DMA_GNT, BR_n_OUT, BR_n_OE, BGACK_n_OUT, BGACK_n_OE
    );

    modport slave (
        output DMA_REQ, DMA_BUSY, BG_n_IN, BGACK_n_IN, AS_n_IN, DTACK_n_IN,
        input  DMA_GNT, BR_n_OUT, BR_n_OE, BGACK_n_OUT, BGACK_n_OE
    );

endinterface

// File: rtl/dma_bus_requester_sync2.sv
// Two-flop synchronizer for an asynchronous active-low bus line; resets to
// the negated level so a reset never looks like a bus event.
module dma_bus_requester_sync2
    import dma_bus_requester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= SYNC_RESET_VAL;
            sync_r <= SYNC_RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/dma_bus_requester.sv
// 68000 bus requester for a local DMA engine: BR/BG/BGACK arbitration with
// bounded tenure, graceful release and a holdoff before re-requesting.
module dma_bus_requester
    import dma_bus_requester_pkg::*;
#(
    parameter logic [7:0] MAX_TENURE = MAX_TENURE_DEF,
    parameter logic [3:0] HOLDOFF    = HOLDOFF_DEF
) (
    input  logic                C7M,
    input  logic                RESET_n,
    dma_bus_requester_if.master bus
);

    logic bg_n_s;
    logic bgack_n_s;
    logic as_n_s;
    logic dtack_n_s;

    dma_bus_requester_sync2 u_sync_bg (
        .clk   (C7M),
        .rst_n (RESET_n),
        .d     (bus.BG_n_IN),
        .q     (bg_n_s)
    );

    dma_bus_requester_sync2 u_sync_bgack (
        .clk   (C7M),
        .rst_n (RESET_n),
        .d     (bus.BGACK_n_IN),
        .q     (bgack_n_s)
    );

    dma_bus_requester_sync2 u_sync_as (
        .clk   (C7M),
        .rst_n (RESET_n),
        .d     (bus.AS_n_IN),
        .q     (as_n_s)
    );

    dma_bus_requester_sync2 u_sync_dtack (
        .clk   (C7M),
        .rst_n (RESET_n),
        .d     (bus.DTACK_n_IN),
        .q     (dtack_n_s)
    );

    state_e     state_r;
    state_e     state_nxt_s;
    logic [7:0] tenure_r;
    logic [7:0] tenure_nxt_s;
    logic [7:0] tenure_inc_s;
    logic [3:0] hold_r;
    logic [3:0] hold_nxt_s;
    logic [3:0] hold_inc_s;
    bus_outs_t  outs_r;
    bus_outs_t  outs_nxt_s;

    // Counters exit on their incremented value so the state leaves on the
    // same edge the count is reached: exactly MAX_TENURE / HOLDOFF cycles.
    always_comb begin
        state_nxt_s  = state_r;
        tenure_nxt_s = tenure_r;
        hold_nxt_s   = hold_r;
        tenure_inc_s = (tenure_r >= MAX_TENURE) ? tenure_r : tenure_r + 8'd1;
        hold_inc_s   = (hold_r >= HOLDOFF) ? hold_r : hold_r + 4'd1;

        case (state_r)
            ST_IDLE: begin
                tenure_nxt_s = 8'd0;
                hold_nxt_s   = 4'd0;
                if (bus.DMA_REQ && bgack_n_s) begin
                    state_nxt_s = ST_REQUEST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (!bus.DMA_REQ) begin
                    state_nxt_s = ST_IDLE;
                end else if (!bg_n_s) begin
                    state_nxt_s = ST_WAIT_FREE;
                end else begin
                    state_nxt_s = ST_REQUEST;
                end
            end
            ST_WAIT_FREE: begin
                if (as_n_s && dtack_n_s && bgack_n_s) begin
                    state_nxt_s  = ST_OWN;
                    tenure_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_WAIT_FREE;
                end
            end
            ST_OWN: begin
                tenure_nxt_s = tenure_inc_s;
                if (!bus.DMA_REQ || (tenure_inc_s >= MAX_TENURE)) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_OWN;
                end
            end
            ST_RELEASE: begin
                if (!bus.DMA_BUSY) begin
                    state_nxt_s = ST_NEGATE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_NEGATE: begin
                hold_nxt_s  = 4'd0;
                state_nxt_s = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                hold_nxt_s = hold_inc_s;
                if (hold_inc_s >= HOLDOFF) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                tenure_nxt_s = 8'd0;
                hold_nxt_s   = 4'd0;
            end
        endcase

        outs_nxt_s = decode_outs(state_nxt_s, state_r == ST_OWN);
    end

    // state, counters and registered bus outputs
    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r  <= ST_IDLE;
            tenure_r <= 8'd0;
            hold_r   <= 4'd0;
            outs_r   <= OUTS_RELEASED;
        end else begin
            state_r  <= state_nxt_s;
            tenure_r <= tenure_nxt_s;
            hold_r   <= hold_nxt_s;
            outs_r   <= outs_nxt_s;
        end
    end

    assign bus.DMA_GNT     = outs_r.dma_gnt;
    assign bus.BR_n_OUT    = outs_r.br_n_out;
    assign bus.BR_n_OE     = outs_r.br_n_oe;
    assign bus.BGACK_n_OUT = outs_r.bgack_n_out;
    assign bus.BGACK_n_OE  = outs_r.bgack_n_oe;

endmodule
